// File: rtl/vga_vram_arbiter.sv
// Single-port video RAM arbiter: VGA scan-out owns every even slot of an active line,
// the ASIP framebuffer port gets all remaining cycles. 320x240 framebuffer shown 2x upscaled.
module vga_vram_arbiter #(
    parameter int AW  = 17,
    parameter int DW  = 8,
    parameter int FBW = 320,
    parameter int FBH = 240,
    parameter int HSS = 144,
    parameter int HSE = 784,
    parameter int VSS = 33,
    parameter int VSE = 513
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    posx,
    input  logic [9:0]    posy,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pixel,
    output logic          pixel_valid
);

    localparam logic [9:0]    X_SLOT_S  = 10'(HSS - 2);
    localparam logic [9:0]    X_SLOT_E  = 10'(HSE - 2);
    localparam logic [9:0]    X_NEXT_S  = 10'(HSS - 1);
    localparam logic [9:0]    X_NEXT_E  = 10'(HSE - 1);
    localparam logic [9:0]    X_END     = 10'(HSE);
    localparam logic [9:0]    Y_S       = 10'(VSS);
    localparam logic [9:0]    Y_E       = 10'(VSE);
    localparam logic          HSS_ODD   = 1'(HSS % 2);
    localparam logic [AW-1:0] FB_SIZE   = AW'(FBW * FBH);
    localparam logic [AW-1:0] LINE_STEP = AW'(FBW);

    logic          line_act_s;
    logic          slot_s;
    logic          oor_s;
    logic          gnt_s;
    logic [DW-1:0] ret_data_s;

    logic [AW-1:0] line_base_q, line_base_d;
    logic [AW-1:0] rd_x_q, rd_x_d;
    logic          par_q, par_d;
    logic          slot_dly_q;
    logic [DW-1:0] pixel_q, pixel_d;
    logic          pvalid_q, pvalid_d;
    logic          rvalid_q, rvalid_d;
    logic          roor_q;
    logic [DW-1:0] rdata_hold_q, rdata_hold_d;

    assign line_act_s = (posy >= Y_S) && (posy < Y_E);
    assign slot_s     = line_act_s && (posx >= X_SLOT_S) && (posx < X_SLOT_E) && (posx[0] == HSS_ODD);
    assign oor_s      = (cpu_addr >= FB_SIZE);
    // Grant is suppressed while reset is asserted so a held request waits for release.
    assign gnt_s      = rst & cpu_req & ~slot_s;
    assign ret_data_s = roor_q ? {DW{1'b0}} : mem_rdata;

    // RAM port steering: display slot first, otherwise the CPU request.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = 1'b0;
        mem_wdata = cpu_wdata;
        cpu_gnt   = gnt_s;
        if (slot_s) begin
            mem_addr = line_base_q + rd_x_q;
            mem_we   = 1'b0;
        end else begin
            mem_addr = cpu_addr;
            mem_we   = gnt_s & cpu_we & ~oor_s;
        end
    end

    // Line base / parity / column counters; each framebuffer line is scanned twice.
    always_comb begin
        line_base_d = line_base_q;
        par_d       = par_q;
        rd_x_d      = rd_x_q;
        if ((posy == Y_S) && (posx == 10'd0)) begin
            line_base_d = {AW{1'b0}};
            par_d       = 1'b0;
        end else if (line_act_s && (posx == X_END)) begin
            par_d = ~par_q;
            if (par_q) begin
                line_base_d = line_base_q + LINE_STEP;
            end else begin
                line_base_d = line_base_q;
            end
        end else begin
            line_base_d = line_base_q;
            par_d       = par_q;
        end
        if (posx == 10'd0) begin
            rd_x_d = {AW{1'b0}};
        end else if (slot_s) begin
            rd_x_d = rd_x_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_x_d = rd_x_q;
        end
    end

    // Pixel pipeline: validity is predicted for the next posx so pixel lines up with it.
    always_comb begin
        pvalid_d = line_act_s && (posx >= X_NEXT_S) && (posx < X_NEXT_E);
        pixel_d  = pixel_q;
        if (!pvalid_d) begin
            pixel_d = {DW{1'b0}};
        end else if (slot_dly_q) begin
            pixel_d = mem_rdata;
        end else begin
            pixel_d = pixel_q;
        end
    end

    // CPU read return: data comes straight from the RAM in the return cycle, then held.
    always_comb begin
        rvalid_d     = gnt_s & ~cpu_we;
        rdata_hold_d = rdata_hold_q;
        if (rvalid_q) begin
            rdata_hold_d = ret_data_s;
        end else begin
            rdata_hold_d = rdata_hold_q;
        end
    end

    assign cpu_rdata   = rvalid_q ? ret_data_s : rdata_hold_q;
    assign cpu_rvalid  = rvalid_q;
    assign pixel       = pixel_q;
    assign pixel_valid = pvalid_q;

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_base_q  <= {AW{1'b0}};
            rd_x_q       <= {AW{1'b0}};
            par_q        <= 1'b0;
            slot_dly_q   <= 1'b0;
            pixel_q      <= {DW{1'b0}};
            pvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            roor_q       <= 1'b0;
            rdata_hold_q <= {DW{1'b0}};
        end else begin
            line_base_q  <= line_base_d;
            rd_x_q       <= rd_x_d;
            par_q        <= par_d;
            slot_dly_q   <= slot_s;
            pixel_q      <= pixel_d;
            pvalid_q     <= pvalid_d;
            rvalid_q     <= rvalid_d;
            roor_q       <= oor_s;
            rdata_hold_q <= rdata_hold_d;
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: reset, scan-out addressing, conflicts, blanking
// throughput, out-of-range accesses and slot boundaries, against a behavioural RAM.
module tb_vga_vram_arbiter;

    localparam int AW  = 17;
    localparam int DW  = 8;
    localparam int FBW = 320;
    localparam int FBH = 240;
    localparam int HSS = 144;
    localparam int HSE = 784;
    localparam int VSS = 33;
    localparam int VSE = 513;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    posx, posy;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid, mem_we, pixel_valid;
    logic [DW-1:0] cpu_rdata, mem_wdata, mem_rdata, pixel;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    bit            ram_ready = 1'b0;
    bit            aa_written = 1'b0;

    int total = 0;
    int bad   = 0;

    vga_vram_arbiter dut (
        .clk(clk), .rst(rst), .posx(posx), .posy(posy),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pixel(pixel), .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, preloaded on its first clock edge.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int a = 0; a < (1 << AW); a++) begin
                ram[a] <= (a < FBW * FBH) ? a[7:0] : 8'h5A;
            end
            ram_ready <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    function automatic logic [7:0] exp_pix(input int a);
        if (a == 5 && aa_written) return 8'hAA;
        if (a >= FBW * FBH) return 8'h5A;
        return a[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic jump(input int x, input int y);
        @(posedge clk);
        #1;
        posx = 10'(x);
        posy = 10'(y);
        #1;
    endtask

    // One full 800-cycle line with per-cycle pixel checks and optional slot/conflict probes.
    task automatic run_line(input int y, input bit count_slots, input bit conflict);
        int n = 0, first = -1, last = -1;
        bit act;
        int a;
        for (int x = 0; x < 800; x++) begin
            jump(x, y);
            if (count_slots) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd100;
            end
            if (conflict && x == HSS) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd5; cpu_wdata = 8'hAA;
            end
            if (conflict && x == HSS + 2) cpu_req = 1'b0;
            #1;
            act = (x >= HSS) && (x < HSE);
            a = ((y - VSS) / 2) * FBW + (x - HSS) / 2;
            check("pixel_valid", {31'd0, pixel_valid}, {31'd0, act});
            check("pixel", {24'd0, pixel}, act ? {24'd0, exp_pix(a)} : 32'd0);
            if (count_slots) begin
                if (!cpu_gnt) begin
                    if (first < 0) first = x;
                    last = x;
                    check("slot_addr", {15'd0, mem_addr}, 32'(n));
                    check("slot_we", {31'd0, mem_we}, 32'd0);
                    n++;
                end
                if (x == HSE - 2) check("gnt_hse_m2", {31'd0, cpu_gnt}, 32'd1);
            end
            if (conflict && x == HSS) check("conf_gnt0", {31'd0, cpu_gnt}, 32'd0);
            if (conflict && x == HSS + 1) begin
                check("conf_gnt1", {31'd0, cpu_gnt}, 32'd1);
                check("conf_we", {31'd0, mem_we}, 32'd1);
                check("conf_addr", {15'd0, mem_addr}, 32'd5);
                aa_written = 1'b1;
            end
            if (y == VSE - 1 && x == HSE - 4) check("last_slot_addr", {15'd0, mem_addr}, 32'd76799);
        end
        cpu_req = 1'b0;
        if (count_slots) begin
            check("slot_count", 32'(n), 32'd320);
            check("slot_first", 32'(first), 32'(HSS - 2));
            check("slot_last", 32'(last), 32'(HSE - 4));
        end
    endtask

    initial begin
        int addrs [10];
        rst = 1'b0; posx = 10'd0; posy = 10'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 17'd0; cpu_wdata = 8'd0;
        repeat (3) jump(0, 0);
        check("rst_gnt", {31'd0, cpu_gnt}, 32'd0);
        check("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        check("rst_pixel", {24'd0, pixel}, 32'd0);
        check("rst_pvalid", {31'd0, pixel_valid}, 32'd0);

        // Read granted, then reset asserted before its return cycle.
        jump(300, 2);
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd7;
        #1;
        check("pre_rst_gnt", {31'd0, cpu_gnt}, 32'd1);
        jump(301, 2);
        rst = 1'b0;
        #1;
        check("mid_rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("mid_rst_gnt", {31'd0, cpu_gnt}, 32'd0);
        check("mid_rst_pixel", {24'd0, pixel}, 32'd0);
        check("mid_rst_pvalid", {31'd0, pixel_valid}, 32'd0);
        jump(302, 2);
        jump(303, 2);
        rst = 1'b1;
        #1;
        check("post_rst_gnt", {31'd0, cpu_gnt}, 32'd1);
        jump(304, 2);
        cpu_req = 1'b0;
        #1;
        check("post_rst_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("post_rst_rdata", {24'd0, cpu_rdata}, 32'd7);

        // Scan-out: slot counting on line 0, conflict on its repeat, next fb line, last line.
        run_line(VSS, 1'b1, 1'b0);
        run_line(VSS + 1, 1'b0, 1'b1);
        run_line(VSS + 2, 1'b0, 1'b0);
        for (int y = VSS + 3; y <= VSE - 2; y++) begin
            jump(0, y);
            jump(HSE, y);
        end
        run_line(VSE - 1, 1'b0, 1'b0);

        // Blanking: ten back-to-back reads.
        for (int i = 0; i < 10; i++) addrs[i] = 1000 + i * 37;
        jump(10, 2);
        for (int i = 0; i < 10; i++) begin
            jump(11 + i, 2);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'(addrs[i]);
            #1;
            check("blank_gnt", {31'd0, cpu_gnt}, 32'd1);
            if (i > 0) begin
                check("blank_rvalid", {31'd0, cpu_rvalid}, 32'd1);
                check("blank_rdata", {24'd0, cpu_rdata}, {24'd0, exp_pix(addrs[i-1])});
            end
        end
        jump(21, 2);
        cpu_req = 1'b0;
        #1;
        check("blank_rvalid_last", {31'd0, cpu_rvalid}, 32'd1);
        check("blank_rdata_last", {24'd0, cpu_rdata}, {24'd0, exp_pix(addrs[9])});
        jump(22, 2);
        check("blank_rvalid_end", {31'd0, cpu_rvalid}, 32'd0);
        check("blank_rdata_hold", {24'd0, cpu_rdata}, {24'd0, exp_pix(addrs[9])});

        // Out-of-range write then read.
        jump(40, 2);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd76800; cpu_wdata = 8'h33;
        #1;
        check("oor_wr_gnt", {31'd0, cpu_gnt}, 32'd1);
        check("oor_wr_we", {31'd0, mem_we}, 32'd0);
        jump(41, 2);
        cpu_we = 1'b0;
        #1;
        check("oor_rd_gnt", {31'd0, cpu_gnt}, 32'd1);
        check("oor_wr_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        jump(42, 2);
        cpu_req = 1'b0;
        #1;
        check("oor_rd_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("oor_rd_rdata", {24'd0, cpu_rdata}, 32'd0);
        jump(43, 2);
        check("oor_rd_hold", {24'd0, cpu_rdata}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the VGA scan-out path and the ASIP's memory-mapped framebuffer port.
- The scan-out path has absolute priority. The framebuffer is 320x240 and is shown 2x-upscaled on a 640x480 timing.
- The block sits between the VGA timing controller (posx/posy counters) and the RAM. It generates pixel data aligned to posx.
- The ASIP gets every slot the display does not use: odd slots in active lines, and all slots in blanking.

Parameters:
- AW, 17, RAM address width.
- DW, 8, pixel/data width.
- FBW, 320, framebuffer width in pixels.
- FBH, 240, framebuffer height in lines.
- HSS, 144, first active posx.
- HSE, 784, first posx after active region.
- VSS, 33, first active posy.
- VSE, 513, first posy after active region.

Ports:
- clk  in  1  system/pixel clock; posx advances once per clk.
- rst  in  1  asynchronous, active-low reset.
- posx  in  10  horizontal counter from the timing controller.
- posy  in  10  vertical counter from the timing controller.
- cpu_req  in  1  ASIP access request, level; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  linear framebuffer address (y*FBW + x).
- cpu_wdata  in  DW  write data.
- cpu_gnt  out  1  one-cycle pulse: access issued this cycle.
- cpu_rdata  out  DW  read data, valid with cpu_rvalid.
- cpu_rvalid  out  1  one-cycle pulse, one cycle after a read grant.
- mem_addr  out  AW  RAM address (combinational).
- mem_we  out  1  RAM write enable (combinational).
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, one cycle after address.
- pixel  out  DW  pixel for the current posx; 0 outside active area.
- pixel_valid  out  1  high when posx/posy are inside the active area.

Behaviour:
- Reset (rst=0, async): all registered outputs and internal state go to 0.
  - Covers cpu_gnt, cpu_rvalid, cpu_rdata, pixel, pixel_valid, line_base, rd_x and the line-parity flag.
  - A read granted in the cycle before reset produces no cpu_rvalid.
  - A cpu_req still held after reset release is serviced normally.
- Display slot: active when posy is in [VSS,VSE) and posx is in [HSS-2,HSE-2) with (posx-HSS) even. That gives 320 slots per active line.
  - mem_addr = line_base + rd_x, mem_we = 0.
  - rd_x increments after each display slot and clears at posx==0.
- Pixel pipeline:
  - RAM data from the slot at posx=p returns at p+1.
  - It is registered into pixel at the edge that makes posx=p+2, then held for 2 cycles.
  - pixel_valid is registered so it is aligned with pixel.
  - pixel is forced to 0 when the current posx/posy are outside the active area.
- Line addressing (no multiplier):
  - At posy==VSS and posx==0: line_base=0 and the parity flag clears.
  - At posx==HSE on an active line: the parity flag toggles. If the line just finished had parity 1, line_base += FBW.
  - Each framebuffer line is therefore shown twice.
- CPU slot: every cycle that is not a display slot.
  - If cpu_req=1: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata, and cpu_gnt=1 combinationally in the same cycle.
  - The requester may present a new request the next cycle, so back-to-back grants are allowed in consecutive free cycles.
- CPU read return: cpu_rvalid=1 and cpu_rdata=mem_rdata in the cycle after a read grant. cpu_rdata holds its value until the next read return.
- Out-of-range CPU address (cpu_addr >= FBW*FBH):
  - Granted, but mem_we is forced to 0.
  - A read returns cpu_rdata=0 with cpu_rvalid=1.
- Priority: when a display slot and cpu_req coincide, the display wins, cpu_gnt=0 and the request waits.
  - Maximum CPU wait is 1 cycle in active lines.
- Posx wrap (799 -> 0) and posy wrap need no special handling beyond the rules above. rd_x clears every line.

Test Plan:
- Reset: rst=0 mid-line with cpu_req=1 and a read granted the previous cycle. Required: cpu_gnt=0, cpu_rvalid=0, pixel=0, pixel_valid=0. After release, the held request is granted on the first free cycle.
- Scan-out addressing: RAM preloaded with mem[a]=a[7:0], one frame run.
  - At posy=VSS, posx=HSS and HSS+1: pixel=0.
  - At posx=HSS+2: pixel=1.
  - posy=VSS+1 repeats line 0.
  - At posy=VSS+2, posx=HSS: pixel=320[7:0]=0x40.
  - At posy=VSE-1, posx=HSE-1: mem_addr was 76799 at its slot.
- Conflict: cpu_req held, write of 0xAA to addr 5 issued at posx=HSS (display slot). Required: cpu_gnt=0 at HSS, cpu_gnt=1 at HSS+1 with mem_we=1. A subsequent scan shows 0xAA at framebuffer pixel 5.
- Blanking throughput: 10 back-to-back reads at posy=2. Required: 10 consecutive cpu_gnt pulses, each cpu_rvalid one cycle later, data matching RAM.
- Out of range: write to addr 76800. Required: cpu_gnt=1 and mem_we=0. Then a read of 76800: cpu_rvalid=1 and cpu_rdata=0.
- Boundary slots: count display slots across a full active line. Required: exactly 320, first at posx=HSS-2, last at posx=HSE-4. cpu_gnt is possible at posx=HSE-2.
